// File: rtl/cnt_seq_ctrl_if.sv
// Signal bundle between the run sequencer, its environment and the attached counter.
// master drives requests and counter feedback; slave is the sequencer itself.
interface cnt_seq_ctrl_if #(parameter int W = 4);
  logic         start;
  logic         stop;
  logic [W-1:0] period;
  logic [3:0]   reps;
  logic [W-1:0] cnt_q;
  logic         cnt_co;
  logic         cnt_load_n;
  logic         cnt_en;
  logic [W-1:0] cnt_d;
  logic         busy;
  logic         tick;
  logic         done;
  logic [3:0]   rep_left;
  logic         err;

  modport master (
    output start, stop, period, reps, cnt_q, cnt_co,
    input  cnt_load_n, cnt_en, cnt_d, busy, tick, done, rep_left, err
  );

  modport slave (
    input  start, stop, period, reps, cnt_q, cnt_co,
    output cnt_load_n, cnt_en, cnt_d, busy, tick, done, rep_left, err
  );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// Run sequencer for an up-counter: preloads ~PERIOD, counts to carry-out, repeats REPS times.
// state | meaning
// IDLE  | waiting for START; period/reps captured on acceptance
// LOAD  | one-cycle counter preload with ~P
// RUN   | counting; carry-out ends an interval, reload or finish
// DONE  | one-cycle completion pulse of a finite run
module cnt_seq_ctrl #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         MR,
  cnt_seq_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] p_q, p_d;
  logic [3:0]   rep_q, rep_d;
  logic         err_q, err_d;
  logic         chk_q, chk_d;

  logic in_load, in_run, busy, co_run, last_rep, reload;

  assign in_load  = (state_q == ST_LOAD);
  assign in_run   = (state_q == ST_RUN);
  assign busy     = in_load | in_run;
  assign co_run   = in_run & bus.cnt_co;
  assign last_rep = (rep_q == 4'd1);
  assign reload   = co_run & ~last_rep;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    rep_d   = rep_q;
    err_d   = err_q;
    chk_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          p_d     = bus.period;
          rep_d   = bus.reps;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
          chk_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (chk_q && (bus.cnt_q != ~p_q)) begin
          err_d = 1'b1;
        end
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (co_run) begin
          if (last_rep) begin
            rep_d   = 4'd0;
            state_d = ST_DONE;
          end else begin
            chk_d = 1'b1;
            // rep_q == 0 marks continuous mode and must never wrap
            if (rep_q != 4'd0) begin
              rep_d = rep_q - 4'd1;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      rep_q   <= 4'd0;
      err_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
    end
  end

  // TICK is the only output gated by STOP, so an aborted interval never reports completion
  assign bus.tick       = co_run & ~bus.stop;
  assign bus.cnt_en     = in_run;
  assign bus.cnt_load_n = ~(in_load | reload);
  assign bus.cnt_d      = busy ? ~p_q : '0;
  assign bus.busy       = busy;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.rep_left   = rep_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl paired with a 4-bit loadable counter model; per-cycle traces
// are predicted from interval arithmetic (PERIOD+1 cycles per interval, REPS intervals).
module tb_cnt_seq_ctrl;

  logic CLK = 1'b0;
  logic MR;
  always #5 CLK = ~CLK;

  cnt_seq_ctrl_if #(.W(4)) bus ();
  cnt_seq_ctrl #(.W(4)) dut (.CLK(CLK), .MR(MR), .bus(bus));

  // attached counter: sync active-low load over enable, carry-out when full and enabled
  logic [3:0] cq_q;
  logic       force_bad;
  always_ff @(posedge CLK or negedge MR) begin
    if (!MR)                  cq_q <= 4'h0;
    else if (!bus.cnt_load_n) cq_q <= force_bad ? 4'h0 : bus.cnt_d;
    else if (bus.cnt_en)      cq_q <= cq_q + 4'h1;
  end
  assign bus.cnt_q  = cq_q;
  assign bus.cnt_co = (&cq_q) & bus.cnt_en;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {busy, tick, done, cnt_en, cnt_load_n, rep_left, cnt_d}
  function automatic logic [12:0] obs();
    return {bus.busy, bus.tick, bus.done, bus.cnt_en, bus.cnt_load_n, bus.rep_left, bus.cnt_d};
  endfunction

  function automatic logic [12:0] pk(bit b, bit t, bit dn, bit en, bit ld,
                                     logic [3:0] r, logic [3:0] d);
    return {b, t, dn, en, ld, r, d};
  endfunction

  // Enter at a negedge in IDLE; leaves at negedge+1 in IDLE.
  // stop_at: trace cycle during which STOP is high (0 = LOAD, n = n-th RUN cycle), -1 = none.
  task automatic run_seq(input int p, input int r, input int stop_at);
    logic [12:0] q[$];
    logic [3:0]  nd;
    int          rem, pos;
    bit          tc, fin, idle_rec;
    nd = ~4'(p);
    q.push_back(pk(1, 0, 0, 0, 0, 4'(r), nd));
    if (stop_at == 0) begin
      q.push_back(pk(0, 0, 0, 0, 1, 4'(r), 4'h0));
    end else begin
      rem = r;
      pos = 0;
      for (int c = 1; c < 400; c++) begin
        tc  = (pos == p);
        fin = tc && (rem == 1);
        q.push_back(pk(1, tc && (stop_at != c), 0, 1, !(tc && !fin), 4'(rem), nd));
        if (stop_at == c) begin
          q.push_back(pk(0, 0, 0, 0, 1, 4'(rem), 4'h0));
          break;
        end
        if (tc) begin
          if (fin) begin
            q.push_back(pk(0, 0, 1, 0, 1, 4'h0, 4'h0));
            q.push_back(pk(0, 0, 0, 0, 1, 4'h0, 4'h0));
            break;
          end
          if (rem > 0) rem--;
          pos = 0;
        end else begin
          pos++;
        end
      end
    end
    bus.period = 4'(p);
    bus.reps   = 4'(r);
    bus.start  = 1'b1;
    bus.stop   = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      idle_rec   = !q[i][12] && !q[i][10];
      bus.stop   = (stop_at == i);
      bus.start  = idle_rec ? 1'b0 : 1'($urandom_range(0, 1));
      if (!idle_rec) begin
        bus.period = 4'($urandom);
        bus.reps   = 4'($urandom);
      end
      #1;
      chk_val("trace", 32'(obs()), 32'(q[i]));
      chk_val("err_clean", 32'(bus.err), 32'h0);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    int p, r, s;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.period = 4'h0;
    bus.reps   = 4'h0;
    force_bad  = 1'b0;
    MR = 1'b1;
    #1 MR = 1'b0;
    #1;
    chk_val("reset_outs", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 4'h0, 4'h0)));
    chk_val("reset_err", 32'(bus.err), 32'h0);
    @(negedge CLK);
    MR = 1'b1;
    @(negedge CLK);
    #1;

    run_seq(3, 2, -1);
    run_seq(0, 0, 21);
    run_seq(15, 1, -1);
    run_seq(3, 3, 4);

    // START and STOP together in IDLE: nothing captured, REP_LEFT keeps 3 from the abort
    bus.start = 1'b1; bus.stop = 1'b1; bus.period = 4'h5; bus.reps = 4'h7;
    @(negedge CLK);
    bus.start = 1'b0; bus.stop = 1'b0;
    #1 chk_val("start_stop_idle", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 4'h3, 4'h0)));
    @(negedge CLK);
    #1 chk_val("start_stop_idle2", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 4'h3, 4'h0)));

    // MR mid-run: asynchronous clear, no DONE afterwards
    bus.period = 4'h5; bus.reps = 4'h3; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (4) @(negedge CLK);
    #2 MR = 1'b0;
    #1;
    chk_val("mr_async_outs", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 4'h0, 4'h0)));
    chk_val("mr_async_err", 32'(bus.err), 32'h0);
    @(negedge CLK);
    MR = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1 chk_val("mr_after", 32'(obs()), 32'(pk(0, 0, 0, 0, 1, 4'h0, 4'h0)));
    end

    // wrong preload: counter loads 0 instead of 4'hC
    force_bad = 1'b1;
    bus.period = 4'h3; bus.reps = 4'h0; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    #1 chk_val("bad_load_d", 32'(bus.cnt_d), 32'hC);
    chk_val("bad_err_load", 32'(bus.err), 32'h0);
    @(negedge CLK);
    #1 chk_val("bad_err_run1", 32'(bus.err), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1 chk_val("bad_err_set", 32'(bus.err), 32'h1);
    end
    bus.stop = 1'b1;
    @(negedge CLK);
    bus.stop = 1'b0;
    #1 chk_val("bad_stop_busy", 32'(bus.busy), 32'h0);
    chk_val("bad_err_hold", 32'(bus.err), 32'h1);
    @(negedge CLK);
    #1 chk_val("bad_err_hold2", 32'(bus.err), 32'h1);
    force_bad = 1'b0;
    run_seq(3, 1, -1);

    for (int k = 0; k < 40; k++) begin
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 4));
      if (r == 0)                          s = int'($urandom_range(0, 30));
      else if ($urandom_range(0, 2) == 0)  s = int'($urandom_range(0, 60));
      else                                 s = -1;
      run_seq(p, r, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
